gf2_poly_divider: RTL and testbench

- Bit-serial carry-less (GF(2)[x]) long divider, the inverse of the three-way Toom-Cook polynomial multiplier.
- Takes a double-width polynomial A (up to 466 bits) and a divisor B (up to 233 bits) and returns quotient Q and remainder R, with A = Q*B xor R and deg(R) < deg(B).
- Used for generic modular reduction and for checking multiplier products in the library's GF(2^233) datapath.

---
 rtl/gf2_pkg.sv | 18 +
 rtl/gf2_div_step.sv | 28 ++
 rtl/gf2_poly_divider.sv | 116 +++++++++++
 tb/tb_gf2_poly_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// Shared constants and state encoding for the GF(2)[x] long divider.
//   N  : divisor / remainder width
//   M  : dividend / quotient width (2*N)
//   CW : bit-counter width, clog2(M)
//   DW : degree-register width, clog2(N)
package gf2_pkg;
  localparam int N  = 233;
  localparam int M  = 466;
  localparam int CW = 9;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/gf2_div_step.sv
// One bit of carry-less long division.
//   rem     : working remainder, deg(rem) < deg
//   din     : next dividend bit (MSB first)
//   b       : divisor, unshifted
//   deg     : degree of b
//   rem_nxt : remainder after shifting in din and conditionally cancelling b
//   q_bit   : quotient bit for this position
module gf2_div_step
  import gf2_pkg::*;
(
  input  logic [N-1:0]  rem,
  input  logic          din,
  input  logic [N-1:0]  b,
  input  logic [DW-1:0] deg,
  output logic [N-1:0]  rem_nxt,
  output logic          q_bit
);
  // t = rem*x + din has degree <= deg, so only t[deg] decides the subtraction
  // and the top bit t[N] is always clear once b has been cancelled.
  logic [N:0] t;

  always_comb begin
    t     = {rem, din};
    q_bit = t[deg];
    if (q_bit) t = t ^ {1'b0, b};
    rem_nxt = t[N-1:0];
  end
endmodule

// File: rtl/gf2_poly_divider.sv
// Bit-serial GF(2)[x] divider: a = q*b xor r, deg(r) < deg(b).
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   start : request, accepted in IDLE or DONE
//   a     : dividend (M bits), b : divisor (N bits)
//   busy  : high while normalising or dividing
//   done  : one-cycle pulse, q/r/dz valid
//   q, r  : quotient / remainder, held until next accepted start
//   dz    : divide-by-zero flag, held with q/r
// Flow: NORM shifts a copy of b left until its MSB is set to find deg(b),
// then DIV consumes one dividend bit per cycle, MSB first.
module gf2_poly_divider
  import gf2_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] q,
  output logic [N-1:0] r,
  output logic         dz
);
  state_t        state;
  logic [M-1:0]  a_l;
  logic [N-1:0]  b_l;
  logic [N-1:0]  bn;
  logic [DW-1:0] deg;
  logic [CW-1:0] cnt;
  logic [N-1:0]  rem;
  // Quotient accumulates here so q stays 0 until done; after M shifts the
  // first bit lands at q[M-1], so the register only needs M-1 bits.
  logic [M-2:0]  qw;

  logic [N-1:0]  rem_nxt;
  logic          q_bit;

  gf2_div_step u_step (
    .rem     (rem),
    .din     (a_l[cnt]),
    .b       (b_l),
    .deg     (deg),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      a_l   <= '0;
      b_l   <= '0;
      bn    <= '0;
      deg   <= '0;
      cnt   <= '0;
      rem   <= '0;
      qw    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_l <= a;
            b_l <= b;
            bn  <= b;
            deg <= DW'(N-1);
            cnt <= CW'(M-1);
            rem <= '0;
            qw  <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
            if (b == '0) begin
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_NORM;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_NORM: begin
          if (bn[N-1]) begin
            state <= S_DIV;
          end else begin
            bn  <= bn << 1;
            deg <= deg - 1'b1;
          end
        end
        S_DIV: begin
          rem <= rem_nxt;
          qw  <= {qw[M-3:0], q_bit};
          if (cnt == '0) begin
            q     <= {qw, q_bit};
            r     <= rem_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gf2_poly_divider.sv
// Directed and reference-model checks for gf2_poly_divider.
module tb_gf2_poly_divider;
  import gf2_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [M-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [M-1:0] q;
  logic [N-1:0] r;
  logic         dz;

  int checks = 0;
  int errors = 0;

  gf2_poly_divider dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] a;
    logic [N-1:0] b;
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;   // edges after the start edge until done is seen
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [M+N-1:0] got, input logic [M+N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [M-1:0] rnd_m();
    logic [M-1:0] v;
    for (int i = 0; i < M; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [M+N-1:0] clmul(input logic [M-1:0] x, input logic [N-1:0] y);
    logic [M+N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++)
      if (y[i]) p = p ^ ({{N{1'b0}}, x} << i);
    return p;
  endfunction

  // Launch one division and wait for done. While busy, q/r/dz must stay 0.
  // With junk set, start is pulsed with b=0 during busy to prove it is ignored.
  task automatic do_op(input logic [M-1:0] aa, input logic [N-1:0] bb, input bit junk,
                       input string tag, output int lat);
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rnd_m();
    b = junk ? '0 : rnd_m()[N-1:0];
    lat = 0;
    while (!done && lat < 800) begin
      if (!busy || q != '0 || r != '0 || dz) bad = 1'b1;
      start = junk && (lat % 50 == 10);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) lat = -1;
    chk({tag, "_busy_hold"}, (M+N)'(bad), '0);
  endtask

  initial begin
    int lat;
    bit bad;
    logic [M-1:0] ra, rx;
    logic [N-1:0] rb, ry, rz, msk;
    logic [M+N-1:0] prod;
    int dys [6];

    // a, b, q, r, dz, latency
    tv[0] = '{M'('h9),    N'('h3), M'('h7),    N'('h0), 1'b0, 698};
    tv[1] = '{M'('hB),    N'('h3), M'('h6),    N'('h1), 1'b0, 698};
    tv[2] = '{M'('h0),    N'('h5), M'('h0),    N'('h0), 1'b0, 697};
    tv[3] = '{M'('h1234), N'('h0), M'('h0),    N'('h0), 1'b1, 0};
    tv[4] = '{M'('h1F),   N'('h7), M'('h4),    N'('h3), 1'b0, 697};
    tv[5] = '{M'('hABCD), N'('h1), M'('hABCD), N'('h0), 1'b0, 699};
    tv[6] = '{(M'(1) << 465) | M'(3), N'(1) << 232, M'(1) << 233, N'('h3), 1'b0, 467};
    tv[7] = '{M'(1) << 232, (N'(1) << 232) | N'(1), M'('h1), N'('h1), 1'b0, 467};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", (M+N)'(busy), '0);
    chk("rst_done", (M+N)'(done), '0);
    chk("rst_q",    (M+N)'(q),    '0);
    chk("rst_r",    (M+N)'(r),    '0);
    chk("rst_dz",   (M+N)'(dz),   '0);
    @(negedge clk) rst = 1'b1;

    // Table vectors run back to back: each start lands in the previous DONE cycle.
    for (int i = 0; i < 8; i++) begin
      do_op(tv[i].a, tv[i].b, 1'b0, $sformatf("tv%0d", i), lat);
      chk($sformatf("tv%0d_lat", i), (M+N)'(lat), (M+N)'(tv[i].lat));
      chk($sformatf("tv%0d_q", i),   (M+N)'(q),   (M+N)'(tv[i].q));
      chk($sformatf("tv%0d_r", i),   (M+N)'(r),   (M+N)'(tv[i].r));
      chk($sformatf("tv%0d_dz", i),  (M+N)'(dz),  (M+N)'(tv[i].dz));
    end

    // done is a single pulse; results hold afterwards.
    @(posedge clk); #1;
    chk("done_pulse", (M+N)'(done), '0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_q", (M+N)'(q), (M+N)'(1));
    chk("hold_r", (M+N)'(r), (M+N)'(1));

    // Divide by zero, then a division with start pulses during busy.
    do_op(M'('h55), N'(0), 1'b0, "dz", lat);
    chk("dz_lat", (M+N)'(lat), '0);
    chk("dz_flag", (M+N)'(dz), (M+N)'(1));
    do_op(M'('h9), N'('h3), 1'b1, "junk", lat);
    chk("junk_lat", (M+N)'(lat), (M+N)'(698));
    chk("junk_q",   (M+N)'(q),   (M+N)'(7));
    chk("junk_r",   (M+N)'(r),   '0);
    chk("junk_dz",  (M+N)'(dz),  '0);

    // Full-degree divisor, random dividend: verify a == q*b ^ r.
    for (int k = 0; k < 10; k++) begin
      ra = rnd_m();
      rb = rnd_m()[N-1:0];
      rb[N-1] = 1'b1;
      do_op(ra, rb, 1'b0, "rnd", lat);
      chk($sformatf("rnd%0d_lat", k), (M+N)'(lat), (M+N)'(467));
      chk($sformatf("rnd%0d_recon", k), clmul(q, rb) ^ (M+N)'(r), (M+N)'(ra));
      chk($sformatf("rnd%0d_rdeg", k), (M+N)'(r[N-1]), '0);
    end

    // Round trip: a = x*y ^ z with deg(z) < deg(y) must give q=x, r=z.
    dys = '{232, 200, 232, 220, 225, 232};
    for (int k = 0; k < 6; k++) begin
      rx  = {{(M-N){1'b0}}, rnd_m()[N-1:0]};
      msk = (N'(1) << dys[k]) - N'(1);
      ry  = (rnd_m()[N-1:0] & msk) | (N'(1) << dys[k]);
      rz  = rnd_m()[N-1:0] & msk;
      prod = clmul(rx, ry) ^ (M+N)'(rz);
      do_op(prod[M-1:0], ry, 1'b0, "rt", lat);
      chk($sformatf("rt%0d_lat", k), (M+N)'(lat), (M+N)'(N - dys[k] + M));
      chk($sformatf("rt%0d_q", k), (M+N)'(q), (M+N)'(rx));
      chk($sformatf("rt%0d_r", k), (M+N)'(r), (M+N)'(rz));
    end

    // Asynchronous reset in the middle of DIV aborts with no done pulse.
    @(negedge clk);
    a = M'('h9); b = N'('h3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (300) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", (M+N)'(busy), '0);
    chk("arst_done", (M+N)'(done), '0);
    chk("arst_q",    (M+N)'(q),    '0);
    chk("arst_r",    (M+N)'(r),    '0);
    chk("arst_dz",   (M+N)'(dz),   '0);
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    @(negedge clk) rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (done || busy) bad = 1'b1;
    end
    chk("arst_quiet", (M+N)'(bad), '0);
    do_op(M'('hB), N'('h3), 1'b0, "post", lat);
    chk("post_lat", (M+N)'(lat), (M+N)'(698));
    chk("post_q",   (M+N)'(q),   (M+N)'(6));
    chk("post_r",   (M+N)'(r),   (M+N)'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
